// File: rtl/bids22_cmd_sequencer_if.sv
// Host-command and core-control signal bundle for the bids22 command sequencer.
// The slave side is the sequencer; the master side is the host plus auction core.
interface bids22_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        ready;
  logic        roundOver;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        busy;
  logic [15:0] round_count;
  logic        to_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, ready, roundOver,
    output cmd_ready, C_op, C_data, C_start, busy, round_count, to_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, ready, roundOver,
    input  cmd_ready, C_op, C_data, C_start, busy, round_count, to_err
  );
endinterface

// File: rtl/bids22_cmd_sequencer.sv
// Command FIFO plus replay FSM driving the bids22 core control inputs; turns
// RUN_ROUND into a C_start window, then waits (with timeout) for roundOver.
module bids22_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  bids22_cmd_sequencer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  logic [3:0]    r_mem_op   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [3:0]    r_c_op;
  logic [31:0]   r_c_data;
  logic          r_c_start;
  logic [15:0]   r_win;
  logic [TW-1:0] r_to_cnt;
  logic [15:0]   r_round_count;
  logic          r_to_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_head_op;
  logic [31:0]   w_head_data;
  logic [15:0]   w_win;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_push      = bus.cmd_valid && !w_full;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty && bus.ready;
  assign w_head_op   = r_mem_op[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  // A zero-length bid window still gets one C_start cycle.
  assign w_win       = (w_head_data[15:0] == 16'd0) ? 16'd1 : w_head_data[15:0];

  assign bus.cmd_ready   = !w_full;
  assign bus.C_op        = r_c_op;
  assign bus.C_data      = r_c_data;
  assign bus.C_start     = r_c_start;
  assign bus.round_count = r_round_count;
  assign bus.to_err      = r_to_err;
  assign bus.busy        = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wptr]   <= bus.cmd_op;
      r_mem_data[r_wptr] <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_c_op        <= 4'h0;
      r_c_data      <= 32'h0;
      r_c_start     <= 1'b0;
      r_win         <= 16'd0;
      r_to_cnt      <= {TW{1'b0}};
      r_round_count <= 16'd0;
      r_to_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_c_op    <= 4'h0;
          r_c_data  <= 32'h0;
          r_c_start <= 1'b0;
          if (w_pop) begin
            if (w_head_op == 4'h0) begin
              r_state <= ST_IDLE;
            end else if (w_head_op == 4'hF) begin
              r_c_start <= 1'b1;
              r_win     <= w_win;
              r_state   <= ST_START;
            end else begin
              r_c_op   <= w_head_op;
              r_c_data <= w_head_data;
              r_state  <= ST_ISSUE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_c_op   <= 4'h0;
          r_c_data <= 32'h0;
          r_state  <= ST_IDLE;
        end
        ST_START: begin
          // r_win counts the C_start cycles still to come, including this one.
          if (r_win <= 16'd1) begin
            r_c_start <= 1'b0;
            r_to_cnt  <= {TW{1'b0}};
            r_state   <= ST_WAIT;
          end else begin
            r_win <= r_win - 16'd1;
          end
        end
        ST_WAIT: begin
          if (bus.roundOver) begin
            r_round_count <= r_round_count + 16'd1;
            r_state       <= ST_IDLE;
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            r_to_err <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        default: begin
          r_c_op    <= 4'h0;
          r_c_data  <= 32'h0;
          r_c_start <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
